// File: rtl/alu_pkg.sv
// Shared definitions for the ALU wrapper family: op codes, flag bit positions
// and the operand-sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_OP_ADD    = 4'd0;
  localparam logic [3:0] ALU_OP_SUB    = 4'd1;
  localparam logic [3:0] ALU_OP_AND    = 4'd2;
  localparam logic [3:0] ALU_OP_OR     = 4'd3;
  localparam logic [3:0] ALU_OP_XOR    = 4'd4;
  localparam logic [3:0] ALU_OP_NOT    = 4'd5;
  localparam logic [3:0] ALU_OP_SHL    = 4'd6;
  localparam logic [3:0] ALU_OP_SHR    = 4'd7;
  localparam logic [3:0] ALU_OP_INC    = 4'd8;
  localparam logic [3:0] ALU_OP_DEC    = 4'd9;
  localparam logic [3:0] ALU_OP_PASS_B = 4'd10;

  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    S_LOAD_A = 2'd0,
    S_LOAD_B = 2'd1,
    S_EXEC   = 2'd2,
    S_HOLD   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/ALU_N_bits.sv
// Combinational N-bit ALU. All arithmetic ops share one ripple-carry adder;
// SUB/DEC carry is the no-borrow carry out of A + ~B + 1 style addition.
module ALU_N_bits
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   control,
  output logic [N-1:0] result,
  output logic [3:0]   flags
);

  logic [N-1:0] add_y;
  logic         add_cin;
  logic [N:0]   carry;
  logic [N-1:0] sum;
  logic         flag_c;
  logic         flag_v;

  always_comb begin
    add_y   = b;
    add_cin = 1'b0;
    case (control)
      ALU_OP_SUB: begin add_y = ~b;   add_cin = 1'b1; end
      ALU_OP_INC: begin add_y = '0;   add_cin = 1'b1; end
      ALU_OP_DEC: begin add_y = '1;   add_cin = 1'b0; end
      default:    begin add_y = b;    add_cin = 1'b0; end
    endcase
  end

  assign carry[0] = add_cin;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ripple
      assign sum[gi]     = a[gi] ^ add_y[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & add_y[gi]) | (a[gi] & carry[gi]) | (add_y[gi] & carry[gi]);
    end
  endgenerate

  always_comb begin
    result = a;
    flag_c = 1'b0;
    flag_v = 1'b0;
    case (control)
      ALU_OP_ADD, ALU_OP_SUB, ALU_OP_INC, ALU_OP_DEC: begin
        result = sum;
        flag_c = carry[N];
        flag_v = carry[N] ^ carry[N-1];
      end
      ALU_OP_AND:    result = a & b;
      ALU_OP_OR:     result = a | b;
      ALU_OP_XOR:    result = a ^ b;
      ALU_OP_NOT:    result = ~a;
      ALU_OP_SHL: begin
        result = {a[N-2:0], 1'b0};
        flag_c = a[N-1];
      end
      ALU_OP_SHR: begin
        result = {1'b0, a[N-1:1]};
        flag_c = a[0];
      end
      ALU_OP_PASS_B: result = b;
      default:       result = a;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_V] = flag_v;
    flags[FLAG_C] = flag_c;
    flags[FLAG_N] = result[N-1];
    flags[FLAG_Z] = (result == '0);
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Handshaked operand sequencer around ALU_N_bits: loads A then B (with op code),
// registers result and flags, holds them until consumed; optional accumulator mode.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             tclk,
  input  logic             reset,
  input  logic             clear,
  input  logic             acc_mode,
  input  logic [3:0]       control,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     out_data,
  output logic [3:0]       out_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] op_count
);

  seq_state_t   state_reg;
  logic [N-1:0] reg_a;
  logic [N-1:0] reg_b;
  logic [3:0]   reg_ctl;
  logic [N-1:0] alu_result;
  logic [3:0]   alu_flags;
  logic         in_hs;
  logic         out_hs;

  ALU_N_bits #(.N(N)) u_alu (
    .a       (reg_a),
    .b       (reg_b),
    .control (reg_ctl),
    .result  (alu_result),
    .flags   (alu_flags)
  );

  // Gated by reset so nothing upstream sees a ready during reset.
  assign in_ready = !reset && ((state_reg == S_LOAD_A) || (state_reg == S_LOAD_B));
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  always_ff @(posedge tclk) begin
    if (reset) begin
      state_reg <= S_LOAD_A;
      reg_a     <= '0;
      reg_b     <= '0;
      reg_ctl   <= '0;
      out_data  <= '0;
      out_flags <= '0;
      out_valid <= 1'b0;
      op_count  <= '0;
    end else if (clear) begin
      // Soft clear drops any operation in flight but keeps the op counter.
      state_reg <= S_LOAD_A;
      reg_a     <= '0;
      reg_b     <= '0;
      reg_ctl   <= '0;
      out_data  <= '0;
      out_flags <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_reg)
        S_LOAD_A: begin
          if (in_hs) begin
            reg_a     <= in_data;
            state_reg <= S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (in_hs) begin
            reg_b     <= in_data;
            reg_ctl   <= control;
            state_reg <= S_EXEC;
          end
        end
        S_EXEC: begin
          out_data  <= alu_result;
          out_flags <= alu_flags;
          out_valid <= 1'b1;
          state_reg <= S_HOLD;
        end
        S_HOLD: begin
          if (out_hs) begin
            op_count  <= op_count + CNT_W'(1);
            out_valid <= 1'b0;
            // Accumulator mode chains the held result straight into operand A.
            if (acc_mode) begin
              reg_a     <= out_data;
              state_reg <= S_LOAD_B;
            end else begin
              state_reg <= S_LOAD_A;
            end
          end
        end
        default: state_reg <= S_LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Randomized and directed bench for alu_operand_sequencer, checked against an
// integer-arithmetic reference model of the ALU and the operation protocol.
module tb_alu_operand_sequencer;
  import alu_pkg::*;

  localparam int N     = 4;
  localparam int CNT_W = 2;

  logic             tclk = 1'b0;
  logic             reset;
  logic             clear;
  logic             acc_mode;
  logic [3:0]       control;
  logic [N-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     out_data;
  logic [3:0]       out_flags;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] op_count;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ops    = 0;

  // Reference model state
  int           model_cnt    = 0;
  bit           model_load_a = 1'b1;
  logic [N-1:0] model_acc    = '0;
  logic [N-1:0] obs_data;
  logic [3:0]   obs_flags;

  alu_operand_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
    .tclk      (tclk),
    .reset     (reset),
    .clear     (clear),
    .acc_mode  (acc_mode),
    .control   (control),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_flags (out_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op_count  (op_count)
  );

  always #5 tclk = ~tclk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tclk);
    @(negedge tclk);
  endtask

  // Returns {v, c, n, z, result} computed with plain signed/unsigned integers.
  function automatic logic [N+3:0] model_alu(input logic [3:0] ctl, input int a, input int b);
    int M, H, r, sa, sb, sr;
    bit c, v;
    logic [N-1:0] rr;
    M = 1 << N;
    H = M / 2;
    sa = (a >= H) ? a - M : a;
    sb = (b >= H) ? b - M : b;
    c = 0; v = 0; r = a;
    case (ctl)
      ALU_OP_ADD:    begin r = (a + b) % M; c = (a + b) >= M; sr = sa + sb; v = (sr >= H) || (sr < -H); end
      ALU_OP_SUB:    begin r = (a - b + M) % M; c = (a >= b); sr = sa - sb; v = (sr >= H) || (sr < -H); end
      ALU_OP_INC:    begin r = (a + 1) % M; c = (a == M - 1); v = (sa == H - 1); end
      ALU_OP_DEC:    begin r = (a + M - 1) % M; c = (a != 0); v = (sa == -H); end
      ALU_OP_AND:    r = a & b;
      ALU_OP_OR:     r = a | b;
      ALU_OP_XOR:    r = a ^ b;
      ALU_OP_NOT:    r = M - 1 - a;
      ALU_OP_SHL:    begin r = (2 * a) % M; c = (a >= H); end
      ALU_OP_SHR:    begin r = a / 2; c = (a % 2) == 1; end
      ALU_OP_PASS_B: r = b;
      default:       r = a;
    endcase
    rr = r[N-1:0];
    return {v, c, (r >= H), (r == 0), rr};
  endfunction

  task automatic apply_reset();
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_out_flags", out_flags, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_op_count", op_count, 0);
    reset = 1'b0;
    #1;
    check_val("rst_release_ready", in_ready, 1);
    model_cnt = 0;
    model_load_a = 1'b1;
  endtask

  // One full operation starting at a negedge; ends at a negedge after the
  // output handshake (or after a clear issued during the hold phase).
  task automatic run_op(input logic [3:0] ctl, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic acc_next, input int stall, input int hold, input bit clr_hold);
    logic [N-1:0] ea;
    logic [N+3:0] exp;
    if (model_load_a) begin
      check_val("ready_load_a", in_ready, 1);
      in_valid = 1'b1; in_data = a; control = 4'($urandom); acc_mode = 1'($urandom);
      tick();
      ea = a;
    end else begin
      ea = model_acc;
    end
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b0; in_data = N'($urandom);
      tick();
      check_val("ready_stall_b", in_ready, 1);
    end
    check_val("ready_load_b", in_ready, 1);
    in_valid = 1'b1; in_data = b; control = ctl;
    tick();
    check_val("exec_out_valid", out_valid, 0);
    check_val("exec_in_ready", in_ready, 0);
    // Garbage on the bus while not ready must be ignored.
    in_data = N'($urandom); control = 4'($urandom); out_ready = 1'($urandom);
    acc_mode = 1'($urandom);
    tick();
    exp = model_alu(ctl, int'(ea), int'(b));
    out_ready = 1'b0;
    check_val("hold_valid", out_valid, 1);
    check_val("hold_data", out_data, exp[N-1:0]);
    check_val("hold_flags", out_flags, exp[N+3:N]);
    check_val("hold_count", op_count, model_cnt);
    obs_data = out_data;
    obs_flags = out_flags;
    for (int i = 0; i < hold; i++) begin
      acc_mode = 1'($urandom); in_data = N'($urandom);
      tick();
      check_val("bp_data", out_data, exp[N-1:0]);
      check_val("bp_flags", out_flags, exp[N+3:N]);
      check_val("bp_in_ready", in_ready, 0);
      check_val("bp_count", op_count, model_cnt);
    end
    if (clr_hold) begin
      clear = 1'b1; out_ready = 1'b1; acc_mode = 1'b1;
      tick();
      clear = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
      check_val("clr_valid", out_valid, 0);
      check_val("clr_data", out_data, 0);
      check_val("clr_flags", out_flags, 0);
      check_val("clr_count", op_count, model_cnt);
      check_val("clr_in_ready", in_ready, 1);
      model_load_a = 1'b1;
    end else begin
      acc_mode = acc_next; out_ready = 1'b1;
      tick();
      out_ready = 1'b0; in_valid = 1'b0; acc_mode = 1'($urandom);
      model_cnt = (model_cnt + 1) % (1 << CNT_W);
      check_val("post_count", op_count, model_cnt);
      check_val("post_valid", out_valid, 0);
      check_val("post_in_ready", in_ready, 1);
      model_load_a = !acc_next;
      model_acc = exp[N-1:0];
    end
    $display("op %0d: ctl=%0d a=%0h b=%0h acc_next=%0b -> data=%0h flags=%b count=%0d",
             n_ops, ctl, ea, b, acc_next, obs_data, obs_flags, op_count);
    n_ops++;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; acc_mode = 1'b0; control = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge tclk);
    apply_reset();

    // Basic add: 3 + 5 overflows signed 4-bit range.
    run_op(ALU_OP_ADD, 4'd3, 4'd5, 1'b0, 0, 0, 1'b0);
    check_val("tp_add_data", obs_data, 8);
    check_val("tp_add_flags", obs_flags, 4'b1010);
    check_val("tp_add_count", op_count, 1);

    // Unsigned wrap-around.
    run_op(ALU_OP_ADD, 4'd15, 4'd1, 1'b0, 0, 0, 1'b0);
    check_val("tp_wrap_data", obs_data, 0);
    check_val("tp_wrap_flags", obs_flags, 4'b0101);

    // Accumulator chain from a fresh reset.
    apply_reset();
    run_op(ALU_OP_ADD, 4'd1, 4'd1, 1'b1, 0, 0, 1'b0);
    check_val("tp_acc1", obs_data, 2);
    run_op(ALU_OP_ADD, 4'd0, 4'd1, 1'b1, 0, 0, 1'b0);
    check_val("tp_acc2", obs_data, 3);
    run_op(ALU_OP_ADD, 4'd0, 4'd1, 1'b0, 0, 0, 1'b0);
    check_val("tp_acc3", obs_data, 4);
    check_val("tp_acc_count", op_count, 3);

    // Backpressure, then the fourth and fifth ops wrap the 2-bit counter.
    run_op(ALU_OP_SUB, 4'd2, 4'd7, 1'b0, 1, 3, 1'b0);
    check_val("tp_cnt4", op_count, 0);
    run_op(ALU_OP_XOR, 4'd9, 4'd5, 1'b0, 0, 0, 1'b0);
    check_val("tp_cnt5", op_count, 1);

    // Reset after A is loaded discards the partial operation.
    in_valid = 1'b1; in_data = 4'd7;
    tick();
    in_valid = 1'b0;
    apply_reset();
    run_op(ALU_OP_SUB, 4'd4, 4'd6, 1'b0, 0, 0, 1'b0);

    // Clear during hold beats the simultaneous output handshake.
    run_op(ALU_OP_OR, 4'd5, 4'd10, 1'b1, 0, 1, 1'b1);
    run_op(ALU_OP_ADD, 4'd6, 4'd1, 1'b0, 0, 0, 1'b0);
    check_val("tp_after_clr", obs_data, 7);

    // Clear with an operand handshake in LOAD_A: operand must not be captured.
    clear = 1'b1; in_valid = 1'b1; in_data = 4'd9;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    run_op(ALU_OP_SUB, 4'd1, 4'd3, 1'b0, 0, 0, 1'b0);
    check_val("tp_clr_hs", obs_data, 14);

    // Randomized operations.
    for (int k = 0; k < 40; k++) begin
      run_op(4'($urandom_range(0, 15)), N'($urandom), N'($urandom), 1'($urandom),
             $urandom_range(0, 2), $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Parametrised, handshaked successor to the registered ALU test wrapper. It accepts operands one at a time over a single N-bit bus with valid/ready flow control, and can run in accumulator mode where the previous result feeds back as operand A. Each operation's control code is captured with operand B. Result and flags are registered and held until consumed. The block sits between the board/bench stimulus source and the display/checker path, wrapping one `ALU_N_bits` instance.

## Interface
Parameters:
- `N`, 4: datapath width (≥2).
- `CNT_W`, 8: width of the completed-operation counter.

Ports:
- `tclk`  in  1  the single clock; every register is updated on its rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the `tclk` rising edge.
- `clear`  in  1  synchronous soft clear; lower priority than `reset`.
- `acc_mode`  in  1  1 = accumulator mode (operand A = previous result).
- `control`  in  4  ALU op code, captured together with operand B.
- `in_data`  in  N  operand bus.
- `in_valid`  in  1  operand present.
- `in_ready`  out  1  block can accept an operand.
- `out_data`  out  N  registered result.
- `out_flags`  out  4  registered flags, packed as {v, c, n, z}.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `op_count`  out  CNT_W  completed operations, counted at output handshakes.

## Operation
- States: `S_LOAD_A`, `S_LOAD_B`, `S_EXEC`, `S_HOLD`. Reset state is `S_LOAD_A`.
- `in_ready` = 1 only in `S_LOAD_A` or `S_LOAD_B`, and never while `reset` = 1.
- `S_LOAD_A`: on `in_valid && in_ready`, `reg_a` ← `in_data`, then go to `S_LOAD_B`.
- `S_LOAD_B`: on handshake, `reg_b` ← `in_data` and `reg_ctl` ← `control`, then go to `S_EXEC`.
- `S_EXEC` (one cycle): `out_data` ← ALU result, `out_flags` ← {v, c, n, z}, then go to `S_HOLD`.
- `S_HOLD`: `out_valid` = 1, and `out_data`/`out_flags` are stable.
  - On `out_valid && out_ready`, `op_count` increments, wrapping modulo 2^CNT_W.
  - Next state is `S_LOAD_B` if `acc_mode` = 1 at that edge, else `S_LOAD_A`.
  - When going to `S_LOAD_B` this way, `reg_a` ← `out_data` on the same edge.
- `acc_mode` is sampled only at the output handshake. The first operation after reset or `clear` always loads A.
- `clear` = 1 in any state:
  - next state is `S_LOAD_A`;
  - `out_valid` drops;
  - `reg_a`, `reg_b`, `out_data` and `out_flags` are cleared to 0;
  - `op_count` is preserved.
- Width rules:
  - The ALU operates on N bits.
  - c is the carry out of the MSB.
  - v is the signed overflow.
  - n = `out_data[N-1]`.
  - z = (`out_data` == 0).
  - There is no width extension; results wrap modulo 2^N.

## Timing
- Reset values: `out_data` = 0, `out_flags` = 0, `out_valid` = 0, `in_ready` = 0 while in reset, `op_count` = 0, internal registers = 0.
- Latency: B is accepted at edge k, the result is registered at edge k+1, and `out_valid` is high from edge k+1 onward.
- The minimum cycle per operation is 4 clocks in normal mode and 3 clocks in accumulator mode (with `out_ready` held at 1).
- Backpressure: with `out_ready` = 0 the block stays in `S_HOLD` indefinitely, and `in_ready` stays 0.
- `reset` mid-operation: at the next edge all state returns to reset values, including `op_count`. Any partially loaded operands are discarded.
- If `clear` and a handshake occur on the same edge, `clear` wins: no operand is captured and `op_count` does not increment.
- `in_data` is ignored whenever `in_ready` = 0.

## Structure
- Shared package `alu_pkg` contains:
  - the op-code constants used by `ALU_N_bits` (`ALU_OP_ADD`, `ALU_OP_SUB`, …);
  - the flag bit indices (`FLAG_V`=3, `FLAG_C`=2, `FLAG_N`=1, `FLAG_Z`=0);
  - the state enum `seq_state_t`.
- One sub-module: the existing `ALU_N_bits #(N)`, instantiated once. The FSM, operand registers and counter live in this block.

## Test plan
- Reset, then `in_data`=3 followed by 5 with `ALU_OP_ADD`, N=4 → `out_data`=8, `out_flags`=4'b1010 (v=1, n=1), `out_valid` rises 1 edge after B is accepted, `op_count`=1 after the handshake.
- Wrap-around: ADD 15 + 1 → `out_data`=0, c=1, z=1, v=0.
- Accumulator: `acc_mode`=1, A=1, then B=1, 1, 1 with ADD → results 2, 3, 4. `in_ready` is never high in `S_LOAD_A` between operations; `op_count`=3.
- Backpressure: hold `out_ready`=0 for 3 cycles after a result → `out_data`/`out_flags` are unchanged, `in_ready`=0, `op_count` is unchanged; it increments on the cycle `out_ready` rises.
- Reset mid-operation (after A loaded) and `clear` during `S_HOLD`:
  - `reset` → all outputs 0 at the next edge, `op_count`=0.
  - `clear` → `out_valid`=0, `op_count` retained, next operand accepted as A.
- Counter wrap: CNT_W=2 with 5 operations → `op_count`=1.
